// File: rtl/plab2_proc_test_mem_responder.sv
// Word-addressed test memory answering val/rdy processor memory requests.
// Responses travel through a 2-entry in-order queue with backpressure.
module plab2_proc_test_mem_responder #(
  parameter int unsigned p_addr_bits    = 10,
  parameter int unsigned p_opaque_nbits = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      memreq_val,
  output logic                      memreq_rdy,
  input  logic                      memreq_msg_type,
  input  logic [p_opaque_nbits-1:0] memreq_msg_opaque,
  input  logic [31:0]               memreq_msg_addr,
  input  logic [31:0]               memreq_msg_data,
  output logic                      memresp_val,
  input  logic                      memresp_rdy,
  output logic                      memresp_msg_type,
  output logic [p_opaque_nbits-1:0] memresp_msg_opaque,
  output logic [31:0]               memresp_msg_data
);

  localparam int unsigned Words = 1 << p_addr_bits;

  logic [31:0]            mem [Words];
  logic [p_addr_bits-1:0] idx;
  logic [31:0]            rdata;
  logic                   enq;
  logic                   deq;

  logic [1:0] cnt_q, cnt_d;
  logic       head_q, head_d;
  logic       tail_q, tail_d;

  logic [1:0]                          type_q;
  logic [1:0][p_opaque_nbits-1:0]      opq_q;
  logic [1:0][31:0]                    data_q;

  // Byte-offset and upper address bits are don't-cares: the space aliases.
  logic unused_addr;
  assign unused_addr = ^{memreq_msg_addr[31:p_addr_bits+2], memreq_msg_addr[1:0]};

  assign idx   = memreq_msg_addr[p_addr_bits+1:2];
  assign rdata = mem[idx];

  // Ready depends only on reset and registered count, never on memresp_rdy.
  assign memreq_rdy  = reset && (cnt_q != 2'd2);
  assign memresp_val = (cnt_q != 2'd0);
  assign enq         = memreq_val && memreq_rdy;
  assign deq         = memresp_val && memresp_rdy;

  assign memresp_msg_type   = type_q[head_q];
  assign memresp_msg_opaque = opq_q[head_q];
  assign memresp_msg_data   = data_q[head_q];

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (enq) tail_d = ~tail_q;
    if (deq) head_d = ~head_q;
    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      type_q <= '0;
      opq_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      if (enq) begin
        type_q[tail_q] <= memreq_msg_type;
        opq_q[tail_q]  <= memreq_msg_opaque;
        data_q[tail_q] <= memreq_msg_type ? '0 : rdata;
      end
    end
  end

  // Storage deliberately has no reset so committed writes survive it.
  always_ff @(posedge clk) begin
    if (enq && memreq_msg_type) mem[idx] <= memreq_msg_data;
  end

endmodule

// File: tb/tb_plab2_proc_test_mem_responder.sv
// Directed bench for the test memory responder: a queue/array reference model
// checked every cycle, plus literal expectations on logged responses.
module tb_plab2_proc_test_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreq_val;
  logic        memreq_rdy;
  logic        memreq_msg_type;
  logic [7:0]  memreq_msg_opaque;
  logic [31:0] memreq_msg_addr;
  logic [31:0] memreq_msg_data;
  logic        memresp_val;
  logic        memresp_rdy;
  logic        memresp_msg_type;
  logic [7:0]  memresp_msg_opaque;
  logic [31:0] memresp_msg_data;

  plab2_proc_test_mem_responder #(.p_addr_bits(10), .p_opaque_nbits(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .memreq_val         (memreq_val),
    .memreq_rdy         (memreq_rdy),
    .memreq_msg_type    (memreq_msg_type),
    .memreq_msg_opaque  (memreq_msg_opaque),
    .memreq_msg_addr    (memreq_msg_addr),
    .memreq_msg_data    (memreq_msg_data),
    .memresp_val        (memresp_val),
    .memresp_rdy        (memresp_rdy),
    .memresp_msg_type   (memresp_msg_type),
    .memresp_msg_opaque (memresp_msg_opaque),
    .memresp_msg_data   (memresp_msg_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { logic t; logic [7:0] op; logic [31:0] d; } resp_t;
  typedef struct { int c; logic t; logic [7:0] op; logic [31:0] d; } rec_t;

  resp_t       mq[$];
  logic [31:0] mm[int];
  rec_t        rlog[$];
  int          alog[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge reset) mq.delete();

  // Reference model: expected responses are derived from request order and a
  // word array; state advances once per cycle after the outputs are checked.
  always @(negedge clk) begin
    resp_t r;
    int    widx;
    logic  acc, dq;
    cyc++;
    if (!reset) begin
      mq.delete();
      chk("rst_rdy",  {31'd0, memreq_rdy},  32'd0);
      chk("rst_val",  {31'd0, memresp_val}, 32'd0);
      chk("rst_data", memresp_msg_data,     32'd0);
    end else begin
      chk("model_rdy", {31'd0, memreq_rdy},  {31'd0, mq.size() < 2});
      chk("model_val", {31'd0, memresp_val}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("model_type", {31'd0, memresp_msg_type}, {31'd0, mq[0].t});
        chk("model_op",   {24'd0, memresp_msg_opaque}, {24'd0, mq[0].op});
        chk("model_data", memresp_msg_data, mq[0].d);
      end
      if (memresp_val && memresp_rdy)
        rlog.push_back('{cyc, memresp_msg_type, memresp_msg_opaque, memresp_msg_data});
      acc = memreq_val && (mq.size() < 2);
      dq  = (mq.size() != 0) && memresp_rdy;
      if (dq) void'(mq.pop_front());
      if (acc) begin
        widx = int'(memreq_msg_addr[11:2]);
        r.t  = memreq_msg_type;
        r.op = memreq_msg_opaque;
        if (memreq_msg_type) begin
          mm[widx] = memreq_msg_data;
          r.d = 32'd0;
        end else begin
          r.d = mm.exists(widx) ? mm[widx] : 32'd0;
        end
        mq.push_back(r);
        alog.push_back(cyc);
      end
    end
  end

  // Presents a request and holds it until accepted; leaves val asserted.
  task automatic send(input logic t, input logic [31:0] a, input logic [31:0] d,
                      input logic [7:0] op);
    logic ok;
    memreq_val        = 1'b1;
    memreq_msg_type   = t;
    memreq_msg_addr   = a;
    memreq_msg_data   = d;
    memreq_msg_opaque = op;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = memreq_rdy;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: request op %h not accepted within 50 cycles", op);
  endtask

  task automatic idle(input int n);
    memreq_val = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_resp(input string name, input int k, input logic t,
                          input logic [7:0] op, input logic [31:0] d);
    if (rlog.size() <= k) begin
      chk({name, "_present"}, rlog.size(), k + 1);
    end else begin
      chk({name, "_type"}, {31'd0, rlog[k].t}, {31'd0, t});
      chk({name, "_op"},   {24'd0, rlog[k].op}, {24'd0, op});
      chk({name, "_data"}, rlog[k].d, d);
    end
  endtask

  function automatic int rcyc(input int k);
    return (rlog.size() > k) ? rlog[k].c : -1000;
  endfunction

  function automatic int acyc(input int k);
    return (alog.size() > k) ? alog[k] : -2000;
  endfunction

  initial begin
    int n, a;
    reset             = 1'b0;
    memresp_rdy       = 1'b1;
    memreq_val        = 1'b1;
    memreq_msg_type   = 1'b1;
    memreq_msg_addr   = 32'h0000_1004;
    memreq_msg_data   = 32'h1234_5678;
    memreq_msg_opaque = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    memreq_val = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    chk("rel_rdy", {31'd0, memreq_rdy},  32'd1);
    chk("rel_val", {31'd0, memresp_val}, 32'd0);
    @(posedge clk);
    #1;

    // Write then read back-to-back.
    n = rlog.size(); a = alog.size();
    send(1'b1, 32'h0000_1004, 32'hdead_beef, 8'h03);
    send(1'b0, 32'h0000_1004, 32'h0,         8'h04);
    idle(3);
    chk_resp("wr_resp", n,     1'b1, 8'h03, 32'h0);
    chk_resp("rd_resp", n + 1, 1'b0, 8'h04, 32'hdead_beef);
    chk("wr_latency",  rcyc(n),     acyc(a) + 1);
    chk("rd_back2back", rcyc(n + 1), rcyc(n) + 1);

    // Backpressure: two reads fill the queue, the third stalls.
    send(1'b1, 32'h0000_1000, 32'h11, 8'h10);
    send(1'b1, 32'h0000_1008, 32'h33, 8'h11);
    send(1'b1, 32'h0000_1010, 32'h55, 8'h12);
    idle(3);
    memresp_rdy = 1'b0;
    n = rlog.size(); a = alog.size();
    send(1'b0, 32'h0000_1000, 32'h0, 8'h01);
    send(1'b0, 32'h0000_1008, 32'h0, 8'h02);
    memreq_msg_addr   = 32'h0000_1010;
    memreq_msg_opaque = 8'h03;
    repeat (3) begin
      @(negedge clk);
      chk("full_rdy_low", {31'd0, memreq_rdy},  32'd0);
      chk("full_val",     {31'd0, memresp_val}, 32'd1);
    end
    @(posedge clk);
    #1;
    memresp_rdy = 1'b1;
    send(1'b0, 32'h0000_1010, 32'h0, 8'h03);
    idle(4);
    chk_resp("bp_r1", n,     1'b0, 8'h01, 32'h11);
    chk_resp("bp_r2", n + 1, 1'b0, 8'h02, 32'h33);
    chk_resp("bp_r3", n + 2, 1'b0, 8'h03, 32'h55);
    chk("bp_op3_accept", acyc(a + 2), rcyc(n) + 1);

    // Aliasing and ignored byte offset.
    n = rlog.size();
    send(1'b1, 32'h0000_1008, 32'hcafe_f00d, 8'h05);
    send(1'b0, 32'h0000_0008, 32'h0,         8'h06);
    send(1'b0, 32'h0000_100b, 32'h0,         8'h07);
    idle(3);
    chk_resp("alias_lo",  n + 1, 1'b0, 8'h06, 32'hcafe_f00d);
    chk_resp("alias_off", n + 2, 1'b0, 8'h07, 32'hcafe_f00d);

    // Streaming reads at full throughput.
    n = rlog.size(); a = alog.size();
    for (int i = 0; i < 8; i++)
      send(1'b0, 32'h0000_1004, 32'h0, 8'(i));
    idle(3);
    for (int i = 0; i < 8; i++) begin
      chk_resp("stream", n + i, 1'b0, 8'(i), 32'hdead_beef);
      chk("stream_acc_cyc",  acyc(a + i), acyc(a) + i);
      chk("stream_resp_cyc", rcyc(n + i), acyc(a) + 1 + i);
    end

    // Reset mid-operation.
    send(1'b1, 32'h0000_1020, 32'h5a5a_5a5a, 8'h08);
    idle(3);
    memresp_rdy = 1'b0;
    send(1'b0, 32'h0000_1000, 32'h0, 8'h09);
    send(1'b0, 32'h0000_1008, 32'h0, 8'h0a);
    memreq_val = 1'b0;
    @(negedge clk);
    chk("pre_rst_val", {31'd0, memresp_val}, 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_val", {31'd0, memresp_val}, 32'd0);
    chk("async_rst_rdy", {31'd0, memreq_rdy},  32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset       = 1'b1;
    memresp_rdy = 1'b1;
    n = rlog.size();
    send(1'b0, 32'h0000_1020, 32'h0, 8'h0b);
    idle(3);
    chk("post_rst_count", rlog.size(), n + 1);
    chk_resp("post_rst_rd", n, 1'b0, 8'h0b, 32'h5a5a_5a5a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/plab2_proc_test_mem_responder.md
Name: plab2_proc_test_mem_responder

Overview:
- Single-port word memory that answers the processor's data-memory (or instruction-memory) requests.
- It is the responder end of the val/rdy memory request/response interface the pipelined processor drives.
- Requests are accepted under val/rdy and perform a read or write on an internal register array.
- The response (read data or write ack) is returned through a 2-entry in-order response queue, with backpressure toward the processor.

Parameters:
- p_addr_bits, 10, number of word-index bits; storage is 2^p_addr_bits 32-bit words.
- p_opaque_nbits, 8, width of the opaque tag echoed from request to response.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- memreq_val  input  1  request valid
- memreq_rdy  output  1  responder can accept a request this cycle
- memreq_msg_type  input  1  0 = read, 1 = write
- memreq_msg_opaque  input  p_opaque_nbits  tag, returned unchanged
- memreq_msg_addr  input  32  byte address
- memreq_msg_data  input  32  write data (ignored for reads)
- memresp_val  output  1  response valid
- memresp_rdy  input  1  consumer accepts response
- memresp_msg_type  output  1  copy of request type
- memresp_msg_opaque  output  p_opaque_nbits  copy of request opaque
- memresp_msg_data  output  32  read data; 0 for write responses

Behaviour:
- Reset asserted (reset==0), asynchronous:
  - queue count goes to 0 and queue entries to 0.
  - memresp_val=0, memresp_msg_* = 0.
  - memreq_rdy=0 while reset is low.
  - Storage array is NOT reset and retains its contents across reset.
- Word index = memreq_msg_addr[p_addr_bits+1:2]. addr[1:0] are ignored (no misalignment error). Upper address bits alias, so the address space wraps modulo 4*2^p_addr_bits bytes.
- Accept: a request is accepted in the cycle where memreq_val && memreq_rdy.
- memreq_rdy = reset deasserted && queue count < 2. There is no combinational path from memresp_rdy or memreq_val to memreq_rdy.
- Read: array read combinationally in the accept cycle. The response {type=0, opaque, data=mem[idx]} is enqueued at the clock edge.
- Write: mem[idx] <= memreq_msg_data at the clock edge of the accept cycle. The response {type=1, opaque, data=0} is enqueued at the same edge.
- Latency: the response is visible on memresp_* the cycle after accept if the queue was empty; otherwise it sits behind older entries. Minimum latency is 1 cycle and throughput is 1 request per cycle when memresp_rdy is held at 1.
- Ordering: responses are strictly in acceptance order. A read accepted in the cycle after a write to the same index returns the new data.
- Response queue: 2 entries, circular, head/tail pointers 1 bit each, count 0..2.
  - memresp_val = (count != 0); memresp_msg_* = head entry.
  - Dequeue when memresp_val && memresp_rdy.
  - Count update: count+1 on enqueue only, count-1 on dequeue only, unchanged on simultaneous enqueue+dequeue.
  - Pointers wrap 1->0.
- Full (count==2): memreq_rdy=0; requests are held by the initiator.
  - If a dequeue happens that cycle, rdy rises the next cycle.
- Empty (count==0): memresp_val=0; memresp_msg_* hold the last head-entry value, so consumers must gate on val.
- Reset mid-operation:
  - Queued responses are discarded immediately (asynchronously).
  - Writes already committed remain in storage.
  - A request presented in the same cycle reset asserts is not accepted.

Test Plan:
- Reset: hold reset=0 for 3 cycles with memreq_val=1 -> memreq_rdy=0, memresp_val=0, memresp_msg_data=0. Release reset -> memreq_rdy=1 next cycle, memresp_val=0.
- Write then read (memresp_rdy=1):
  - Write addr 0x1004, data 0xdeadbeef, opaque 0x03, then read addr 0x1004, opaque 0x04, back to back.
  - -> Resp1 {type 1, op 0x03, data 0} at accept+1; resp2 {type 0, op 0x04, data 0xdeadbeef} at next cycle.
  - memresp_val high for 2 consecutive cycles.
- Backpressure:
  - Preload mem[0x1000]=0x11, mem[0x1008]=0x33. Set memresp_rdy=0 and issue reads 0x1000 op1, 0x1008 op2, 0x1010 op3.
  - -> Two are accepted; memreq_rdy=0 with count 2; op3 is stalled.
  - Raise memresp_rdy -> responses op1/0x11, op2/0x33 in order. memreq_rdy=1 the cycle after the first dequeue; op3 is accepted then.
- Aliasing/alignment: write 0xcafef00d to 0x1008, read 0x0008 and 0x100b -> both return 0xcafef00d.
- Streaming: 8 consecutive reads with memresp_rdy=1 and a constant val -> one response per cycle, opaques 0..7 in order, and count never exceeds 1.
- Reset mid-operation:
  - Write 0x5a5a5a5a to 0x1020, then fill the queue with 2 reads (memresp_rdy=0).
  - Pulse reset low -> memresp_val drops immediately.
  - After release, read 0x1020 -> 0x5a5a5a5a.
